// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver that maps drone-control keys to one-hot messages.
// Optional PS2_ERR_COUNT_EN adds a saturating frame-error counter (err_count, err_clr).
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int PULSE_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_encoding,
    output logic       new_ps2_msg,
    output logic       frame_err
`ifdef PS2_ERR_COUNT_EN
    ,
    input  logic       err_clr,
    output logic [7:0] err_count
`endif
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;
    logic [1:0] clk_sync, data_sync;
    logic [FW-1:0] filt_cnt;
    logic filt_clk, filt_clk_d, strobe;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shreg, shreg_nx;
    logic par, par_nx;
    logic [TW-1:0] tcnt;
    logic timeout, byte_ok, err_nx, byte_valid, ext;
    logic [PW-1:0] pcnt;
    logic [6:0] onehot;
    assign strobe  = filt_clk_d & ~filt_clk;
    assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign new_ps2_msg = pcnt != '0;
    assign onehot = ext ? (shreg == 8'h75 ? 7'h20 : shreg == 8'h72 ? 7'h40 : 7'h00) :
                    shreg == 8'h1D ? 7'h01 : shreg == 8'h1C ? 7'h02 :
                    shreg == 8'h1B ? 7'h04 : shreg == 8'h23 ? 7'h08 :
                    shreg == 8'h29 ? 7'h10 : 7'h00;
    // Synchronizers and filter idle high so reset never fabricates a falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            filt_clk_d <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        par_nx     = par;
        byte_ok    = 1'b0;
        err_nx     = 1'b0;
        if (timeout) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
        end else if (strobe) begin
            case (state)
                IDLE: if (!data_sync[1]) begin
                    state_nx   = DATA;
                    bit_cnt_nx = 3'd0;
                end
                DATA: begin
                    shreg_nx   = {data_sync[1], shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    state_nx   = bit_cnt == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_nx   = data_sync[1];
                    state_nx = STOP;
                end
                default: begin
                    state_nx = IDLE;
                    byte_ok  = data_sync[1] & ^{shreg, par};
                    err_nx   = ~byte_ok;
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shreg      <= shreg_nx;
            par        <= par_nx;
            tcnt       <= (state == IDLE || strobe) ? '0 : tcnt + 1'b1;
            byte_valid <= byte_ok;
            frame_err  <= err_nx;
        end
    end
    // E0 only arms the extended flag; F0 emits the release marker and keeps ext for E0 F0 xx
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_encoding <= '0;
            pcnt         <= '0;
            ext          <= 1'b0;
        end else begin
            if (pcnt != '0) pcnt <= pcnt - 1'b1;
            if (frame_err) begin
                ext <= 1'b0;
            end else if (byte_valid) begin
                if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    key_encoding <= shreg == 8'hF0 ? 8'h80 : {1'b0, onehot};
                    pcnt         <= PW'(PULSE_CYCLES);
                    if (shreg != 8'hF0) ext <= 1'b0;
                end
            end
        end
    end
`ifdef PS2_ERR_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_count <= '0;
        else if (err_clr) err_count <= '0;
        else if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench driving PS/2 frames into ps2_key_decoder.
module tb_ps2_key_decoder;
    localparam int HP = 10;
    localparam int LAT = 2 + 8 + 2;
    localparam int PULSE = 4;
    localparam int TIMEOUT = 50000;
    logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] key_encoding;
    logic new_ps2_msg, frame_err;
`ifdef PS2_ERR_COUNT_EN
    logic err_clr = 1'b0;
    logic [7:0] err_count;
`endif
    int checks = 0, passes = 0;
    int cyc = 0, stop_cyc = 0, last_lat = 0, err_seen = 0, err_cyc = 0, width = 0;
    logic [7:0] exp_q[$], obs_q[$];
    int wid_q[$];
    logic prev_msg = 1'b0;

    ps2_key_decoder dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_encoding(key_encoding), .new_ps2_msg(new_ps2_msg), .frame_err(frame_err)
`ifdef PS2_ERR_COUNT_EN
        , .err_clr(err_clr), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (new_ps2_msg && !prev_msg) begin
            obs_q.push_back(key_encoding);
            last_lat = cyc - stop_cyc;
            width = 0;
        end
        if (new_ps2_msg) width++;
        if (!new_ps2_msg && prev_msg) wid_q.push_back(width);
        if (frame_err) begin
            err_seen++;
            err_cyc = cyc;
        end
        prev_msg = new_ps2_msg;
    end

    function automatic logic [10:0] mk(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b0;
            stop_cyc = cyc;
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic bad);
        send_bits(mk(b, bad), 11);
        repeat (2 * HP) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic test_reset;
        logic [7:0] e, o;
        int w;
        repeat (3) @(negedge clk);
        checks++; if (key_encoding !== 8'h00) $display("FAIL rst_key: got %h, expected 00", key_encoding); else passes++;
        checks++; if (new_ps2_msg !== 1'b0) $display("FAIL rst_msg: got %b, expected 0", new_ps2_msg); else passes++;
        checks++; if (frame_err !== 1'b0) $display("FAIL rst_err: got %b, expected 0", frame_err); else passes++;
        reset = 1'b0;
        send(8'h29, 1'b0); exp_q.push_back(8'h10);
        repeat (40) @(negedge clk);
        send_bits(mk(8'h1D, 1'b0), 5);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (key_encoding !== 8'h00) $display("FAIL midrst_key: got %h, expected 00", key_encoding); else passes++;
        checks++; if (new_ps2_msg !== 1'b0) $display("FAIL midrst_msg: got %b, expected 0", new_ps2_msg); else passes++;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send(8'h1D, 1'b0); exp_q.push_back(8'h01);
        repeat (40) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL reset_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL reset_key: got %h, expected %h", o, e); else passes++;
            if (wid_q.size() > 0) begin
                w = wid_q.pop_front();
                checks++; if (w != PULSE) $display("FAIL reset_width: got %0d, expected %0d", w, PULSE); else passes++;
            end
        end
        exp_q.delete(); obs_q.delete(); wid_q.delete();
    endtask

    task automatic test_break;
        logic [7:0] e, o;
        int w;
        send(8'hF0, 1'b0); exp_q.push_back(8'h80);
        send(8'h1C, 1'b0); exp_q.push_back(8'h02);
        repeat (40) @(negedge clk);
        checks++; if (last_lat != LAT) $display("FAIL break_latency: got %0d, expected %0d", last_lat, LAT); else passes++;
        checks++; if (key_encoding !== 8'h02) $display("FAIL break_hold: got %h, expected 02", key_encoding); else passes++;
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL break_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL break_key: got %h, expected %h", o, e); else passes++;
            if (wid_q.size() > 0) begin
                w = wid_q.pop_front();
                checks++; if (w != PULSE) $display("FAIL break_width: got %0d, expected %0d", w, PULSE); else passes++;
            end
        end
        exp_q.delete(); obs_q.delete(); wid_q.delete();
    endtask

    task automatic test_extended;
        logic [7:0] e, o;
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0); exp_q.push_back(8'h20);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0); exp_q.push_back(8'h80);
        send(8'h72, 1'b0); exp_q.push_back(8'h40);
        send(8'h75, 1'b0); exp_q.push_back(8'h00);
        repeat (40) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL ext_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL ext_key: got %h, expected %h", o, e); else passes++;
        end
        exp_q.delete(); obs_q.delete(); wid_q.delete();
    endtask

    task automatic test_parity_err;
        logic [7:0] e, o;
        int e0;
        send(8'hF0, 1'b0); exp_q.push_back(8'h80);
        e0 = err_seen;
        send(8'h29, 1'b1);
        checks++; if (err_seen != e0 + 1) $display("FAIL par_err: got %0d pulses, expected %0d", err_seen - e0, 1); else passes++;
        checks++; if (key_encoding !== 8'h80) $display("FAIL par_hold: got %h, expected 80", key_encoding); else passes++;
        send(8'h29, 1'b0); exp_q.push_back(8'h10);
        send(8'hE0, 1'b0);
        send(8'h1D, 1'b1);
        send(8'h75, 1'b0); exp_q.push_back(8'h00);
        repeat (40) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL par_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL par_key: got %h, expected %h", o, e); else passes++;
        end
        exp_q.delete(); obs_q.delete(); wid_q.delete();
    endtask

    task automatic test_timeout;
        logic [7:0] e, o;
        int e0, t0, lat;
        send(8'hE0, 1'b0);
        send_bits(mk(8'h23, 1'b0), 4);
        e0 = err_seen;
        t0 = stop_cyc;
        for (int i = 0; i < TIMEOUT + 100 && err_seen == e0; i++) @(negedge clk);
        checks++; if (err_seen != e0 + 1) $display("FAIL timeout_err: got %0d pulses, expected 1", err_seen - e0); else passes++;
        lat = err_cyc - t0;
        checks++; if (lat < TIMEOUT || lat > TIMEOUT + 20) $display("FAIL timeout_time: got %0d, expected %0d..%0d", lat, TIMEOUT, TIMEOUT + 20); else passes++;
        send(8'h23, 1'b0); exp_q.push_back(8'h08);
        repeat (40) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL timeout_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL timeout_key: got %h, expected %h", o, e); else passes++;
        end
        exp_q.delete(); obs_q.delete(); wid_q.delete();
    endtask

    task automatic test_glitch;
        logic [7:0] e, o;
        logic [10:0] f;
        int e0;
        e0 = err_seen;
        f = mk(8'h1B, 1'b0);
        send_bits(f, 4);
        @(negedge clk) ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HP) @(negedge clk);
        send_bits(f >> 4, 7);
        repeat (2 * HP) @(negedge clk);
        exp_q.push_back(8'h04);
        repeat (40) @(negedge clk);
        checks++; if (err_seen != e0) $display("FAIL glitch_err: got %0d pulses, expected 0", err_seen - e0); else passes++;
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL glitch_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL glitch_key: got %h, expected %h", o, e); else passes++;
        end
        exp_q.delete(); obs_q.delete(); wid_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] e, o;
        int w;
        send(8'hF0, 1'b0); exp_q.push_back(8'h80);
        send(8'h1D, 1'b0); exp_q.push_back(8'h01);
        send(8'h29, 1'b0); exp_q.push_back(8'h10);
        send(8'h29, 1'b0); exp_q.push_back(8'h10);
        repeat (40) @(negedge clk);
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); else passes++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL b2b_key: got %h, expected %h", o, e); else passes++;
            if (wid_q.size() > 0) begin
                w = wid_q.pop_front();
                checks++; if (w != PULSE) $display("FAIL b2b_width: got %0d, expected %0d", w, PULSE); else passes++;
            end
        end
        exp_q.delete(); obs_q.delete(); wid_q.delete();
    endtask

`ifdef PS2_ERR_COUNT_EN
    task automatic test_err_count;
        checks++; if (err_count !== 8'(err_seen)) $display("FAIL errcnt_pre: got %0d, expected %0d", err_count, err_seen); else passes++;
        for (int i = 0; i < 300; i++) begin
            send_bits(mk(8'h29, 1'b1), 11);
            repeat (4) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++; if (err_count !== 8'hFF) $display("FAIL errcnt_sat: got %h, expected ff", err_count); else passes++;
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        checks++; if (err_count !== 8'h00) $display("FAIL errcnt_clr: got %h, expected 00", err_count); else passes++;
        obs_q.delete(); wid_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_break();
        test_extended();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_back_to_back();
`ifdef PS2_ERR_COUNT_EN
        test_err_count();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #(10 * 400000);
        $display("FAIL watchdog: got no finish, expected finish within 400000 cycles");
        $fatal(1);
    end
endmodule
